// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with a hardware call/return stack.
//
// Generates the instruction fetch address. Each cycle, exactly one action
// is taken, chosen by this priority:
//   stall > ret > call > jump > branch > increment
// A call pushes pc+1 and then jumps to target. A ret pops the most recent
// return address into pc. If a call arrives while the stack is full, or a
// ret while it is empty, the stack is left unchanged and pc advances by one.
// The matching sticky fault flag (ovf or udf) is then set and stays set
// until fault_clr.
//
// Parameters:
//   PC_W        program-counter / target width
//   STACK_DEPTH call-stack entries (power of two, >= 2)
//   RESET_VEC   pc value loaded on reset
//
// Ports:
//   clk, reset     rising-edge clock; asynchronous active-high reset
//   stall          hold pc, stack and flags (fault_clr still honoured)
//   jump           pc <= target
//   branch         pc <= pc + target (signed offset, base is current pc)
//   call           push pc+1, pc <= target
//   ret            pop return address into pc
//   target         jump/call address or branch offset
//   fault_clr      clear ovf/udf (a same-cycle set event wins)
//   pc             current program counter
//   depth          number of valid stack entries
//   stack_full     depth == STACK_DEPTH
//   stack_empty    depth == 0
//   ovf, udf       sticky overflow / underflow faults
//   tos            (only with PC_STACK_TOS_EN) registered top-of-stack value,
//                  0 when the stack is empty
//
// Optional feature macro: PC_STACK_TOS_EN adds the registered tos output.

module pc_stack_unit #(
    parameter int              PC_W        = 19,
    parameter int              STACK_DEPTH = 16,
    parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         jump,
    input  logic                         branch,
    input  logic                         call,
    input  logic                         ret,
    input  logic [PC_W-1:0]              target,
    input  logic                         fault_clr,
    output logic [PC_W-1:0]              pc,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         ovf,
    output logic                         udf
`ifdef PC_STACK_TOS_EN
    ,
    output logic [PC_W-1:0]              tos
`endif
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic            mem_we;
    logic [AW-1:0]   push_idx;
    logic [AW-1:0]   pop_idx;
    logic [PC_W-1:0] pc_inc;
    logic            full;
    logic            empty;

`ifdef PC_STACK_TOS_EN
    logic [PC_W-1:0] tos_q, tos_d;
    logic [AW-1:0]   below_idx;
`endif

    assign full     = (depth_q == DW'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    assign pc_inc   = pc_q + PC_W'(1);
    // When the stack is full, the low AW bits of depth are zero.
    // Index arithmetic modulo STACK_DEPTH therefore still selects the
    // correct entry.
    assign push_idx = depth_q[AW-1:0];
    assign pop_idx  = depth_q[AW-1:0] - AW'(1);
`ifdef PC_STACK_TOS_EN
    assign below_idx = depth_q[AW-1:0] - AW'(2);
`endif

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        mem_we  = 1'b0;
`ifdef PC_STACK_TOS_EN
        tos_d   = tos_q;
`endif

        // Clear first so that a set event later in this block overrides it.
        if (fault_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (!stall) begin
            if (ret) begin
                if (empty) begin
                    pc_d  = pc_inc;
                    udf_d = 1'b1;
                end else begin
                    pc_d    = mem[pop_idx];
                    depth_d = depth_q - DW'(1);
`ifdef PC_STACK_TOS_EN
                    tos_d   = (depth_q > DW'(1)) ? mem[below_idx] : '0;
`endif
                end
            end else if (call) begin
                if (full) begin
                    pc_d  = pc_inc;
                    ovf_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    pc_d    = target;
                    depth_d = depth_q + DW'(1);
`ifdef PC_STACK_TOS_EN
                    tos_d   = pc_inc;
`endif
                end
            end else if (jump) begin
                pc_d = target;
            end else if (branch) begin
                pc_d = pc_q + target;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
`ifdef PC_STACK_TOS_EN
            tos_q   <= '0;
`endif
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
`ifdef PC_STACK_TOS_EN
            tos_q   <= tos_d;
`endif
        end
    end

    // Stack storage is not reset; entries above depth are don't-care.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[push_idx] <= pc_inc;
        end
    end

    assign pc          = pc_q;
    assign depth       = depth_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign ovf         = ovf_q;
    assign udf         = udf_q;
`ifdef PC_STACK_TOS_EN
    assign tos         = tos_q;
`endif

endmodule
